dds_sweep_ctrl: RTL
===================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter STEP_WIDTH, default 32, giving the width of the DDS phase-step word.
REQ-002 The block SHALL have parameter DWELL_WIDTH, default 24, giving the width of the dwell counter in clk cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: pulse that begins a sweep from IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: pulse that aborts a sweep.
REQ-007 The block SHALL have port mode, input, 2 bits: 0 single, 1 repeat (sawtooth), 2 triangle, 3 reserved and treated as 0.
REQ-008 The block SHALL have port start_step, input, STEP_WIDTH bits: unsigned first step value.
REQ-009 The block SHALL have port stop_step, input, STEP_WIDTH bits: unsigned final step value.
REQ-010 The block SHALL have port delta, input, STEP_WIDTH bits: unsigned increment per hop.
REQ-011 The block SHALL have port dwell, input, DWELL_WIDTH bits: cycles each step is held, with 0 treated as 1.
REQ-012 The block SHALL have port step_out, output, STEP_WIDTH bits: step word to the DDS.
REQ-013 The block SHALL have port step_load, output, 1 bit: one-cycle pulse in the cycle step_out takes a new value.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a sweep is running.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when a single-mode sweep completes.

Function
REQ-016 The FSM SHALL have states IDLE and RUN; done SHALL be a registered pulse, not a state.
REQ-017 In IDLE, start=1 with stop=0 SHALL capture mode, start_step, stop_step, delta and dwell into shadow registers and enter RUN; the inputs SHALL NOT be sampled again during the sweep.
REQ-018 In the cycle after start, step_out SHALL equal start_step, step_load SHALL be 1 and busy SHALL be 1.
REQ-019 Each step SHALL be held for max(dwell,1) cycles; if step_load is high at cycle T, the next step_load SHALL occur at T+max(dwell,1).
REQ-020 The next step SHALL be computed at STEP_WIDTH+1 bits as cur+delta when direction is up, and SHALL be clamped to stop_step when the sum is at or above stop_step, including on carry-out.
REQ-021 When direction is down in triangle mode, the next step SHALL be cur-delta, clamped to start_step when the result is at or below start_step, including on borrow.
REQ-022 In single mode, after the dwell of the step equal to stop_step expires, done SHALL pulse for 1 cycle, busy SHALL fall in that same cycle, the FSM SHALL return to IDLE, and step_out SHALL hold its last value.
REQ-023 In repeat mode, the hop after stop_step SHALL reload start_step, and the sweep SHALL never complete on its own.
REQ-024 In triangle mode, direction SHALL reverse on reaching stop_step (to down) and on reaching start_step (to up); the endpoint values SHALL each be emitted once per turn, not twice.
REQ-025 If delta=0 or start_step>=stop_step, the sweep SHALL emit start_step once, hold it for the dwell, and then behave as having reached stop (single mode: done; repeat mode: reload start_step; triangle mode: hold start_step).
REQ-026 stop=1 in RUN SHALL return the FSM to IDLE in the next cycle with busy=0, no done pulse, no step_load, and step_out held.
REQ-027 start in RUN SHALL be ignored; when start and stop are both high in IDLE, stop SHALL win and the FSM SHALL stay in IDLE.
REQ-028 A start in the cycle done pulses SHALL be accepted, because the FSM is already in IDLE.

Reset
REQ-029 reset=0 at a clock edge SHALL, on that edge, set step_out=0, step_load=0, busy=0, done=0, state=IDLE, direction=up, and clear the dwell counter and all shadow registers, overriding any sweep in progress.
REQ-030 No output SHALL pulse in the cycle after reset is released unless start is asserted in that cycle.

Verification
REQ-031 Single sweep, start=100, stop=130, delta=10, dwell=2, start at N -> step_load at N+1/N+3/N+5/N+7 with values 100/110/120/130, done and busy falling at N+9.
REQ-032 Clamp, start=0, stop=25, delta=10, dwell=1 -> values 0,10,20,25 on consecutive cycles, then done.
REQ-033 Triangle, start=0, stop=20, delta=10, dwell=1 -> values 0,10,20,10,0,10,20,... with no done for 20 cycles; repeat mode with the same inputs -> values 0,10,20,0,10,20,....
REQ-034 Overflow, start=0xFFFFFFF0, stop=0xFFFFFFFF, delta=0x20 -> values 0xFFFFFFF0 then 0xFFFFFFFF, then done.
REQ-035 Abort, stop pulsed mid-dwell at value 110 -> busy=0 next cycle, no done, step_out stays 110; a later start with dwell=0 -> one cycle per step.
REQ-036 Reset mid-sweep, reset=0 for 1 cycle -> all outputs 0 and IDLE next cycle; start and stop asserted together in IDLE -> no activity.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//   Frequency-sweep controller for a DDS. On start it captures the sweep
//   parameters into shadow registers and walks the phase-step word from
//   start_step towards stop_step in hops of delta. Each value is held for
//   max(dwell,1) clocks. Single mode finishes with a done pulse. Repeat mode
//   reloads start_step after stop_step. Triangle mode bounces between the
//   two endpoints.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-low reset
//   start       : pulse, begins a sweep from IDLE (stop has priority)
//   stop        : pulse, aborts a running sweep
//   mode        : 0 single, 1 repeat (sawtooth), 2 triangle, 3 behaves as 0
//   start_step  : first step value (unsigned)
//   stop_step   : final step value (unsigned)
//   delta       : increment per hop (unsigned)
//   dwell       : clocks each step is held (0 behaves as 1)
//   step_out    : step word to the DDS
//   step_load   : one-cycle strobe when step_out takes a new value
//   busy        : high while a sweep is running
//   done        : one-cycle strobe when a single-mode sweep completes
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
  parameter int STEP_WIDTH  = 32,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [STEP_WIDTH-1:0]  start_step,
  input  logic [STEP_WIDTH-1:0]  stop_step,
  input  logic [STEP_WIDTH-1:0]  delta,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [STEP_WIDTH-1:0]  step_out,
  output logic                   step_load,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'd0,
    MODE_REPEAT   = 2'd1,
    MODE_TRIANGLE = 2'd2
  } sweep_mode_t;

  // State and shadow registers
  state_t                 state_q,      state_d;
  sweep_mode_t            mode_q,       mode_d;
  logic [STEP_WIDTH-1:0]  start_step_q, start_step_d;
  logic [STEP_WIDTH-1:0]  stop_step_q,  stop_step_d;
  logic [STEP_WIDTH-1:0]  delta_q,      delta_d;
  logic [DWELL_WIDTH-1:0] dwell_m1_q,   dwell_m1_d;   // max(dwell,1)-1
  logic [DWELL_WIDTH-1:0] cnt_q,        cnt_d;        // clocks left on this step
  logic                   dir_down_q,   dir_down_d;
  logic [STEP_WIDTH-1:0]  step_q,       step_d;
  logic                   step_load_q,  step_load_d;
  logic                   done_q,       done_d;

  // Hop arithmetic, one bit wider so carry and borrow are visible
  logic [STEP_WIDTH:0]    sum_up;
  logic [STEP_WIDTH:0]    diff_dn;
  logic [STEP_WIDTH-1:0]  next_up;
  logic [STEP_WIDTH-1:0]  next_dn;
  logic                   degenerate;
  logic                   at_stop;

  always_comb begin
    sum_up  = {1'b0, step_q} + {1'b0, delta_q};
    diff_dn = {1'b0, step_q} - {1'b0, delta_q};
    next_up = (sum_up >= {1'b0, stop_step_q}) ? stop_step_q : sum_up[STEP_WIDTH-1:0];
    next_dn = (diff_dn[STEP_WIDTH] || (diff_dn[STEP_WIDTH-1:0] <= start_step_q))
              ? start_step_q : diff_dn[STEP_WIDTH-1:0];
    // A sweep that cannot advance behaves as if it sits on stop_step already.
    degenerate = (delta_q == '0) || (start_step_q >= stop_step_q);
    at_stop    = degenerate || (!dir_down_q && (step_q == stop_step_q));
  end

  // NOTE: every _d gets its hold value before any branch, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    start_step_d = start_step_q;
    stop_step_d  = stop_step_q;
    delta_d      = delta_q;
    dwell_m1_d   = dwell_m1_q;
    cnt_d        = cnt_q;
    dir_down_d   = dir_down_q;
    step_d       = step_q;
    step_load_d  = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d      = RUN;
          mode_d       = (mode == 2'd3) ? MODE_SINGLE : sweep_mode_t'(mode);
          start_step_d = start_step;
          stop_step_d  = stop_step;
          delta_d      = delta;
          dwell_m1_d   = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
          cnt_d        = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
          dir_down_d   = 1'b0;
          step_d       = start_step;
          step_load_d  = 1'b1;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else begin
          cnt_d = dwell_m1_q;
          if (at_stop) begin
            unique case (mode_q)
              MODE_REPEAT: begin
                step_d      = start_step_q;
                step_load_d = 1'b1;
              end
              // Only a degenerate triangle sweep gets here; it parks on start_step.
              MODE_TRIANGLE: ;
              default: begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            endcase
          end else if (!dir_down_q) begin
            step_d      = next_up;
            step_load_d = 1'b1;
            // Turning at the top here means stop_step is emitted exactly once.
            dir_down_d  = (mode_q == MODE_TRIANGLE) && (next_up == stop_step_q);
          end else begin
            step_d      = next_dn;
            step_load_d = 1'b1;
            dir_down_d  = (next_dn != start_step_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // synchronous reset clears the shadow registers too so a fresh sweep never
  // sees parameters from an aborted one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= MODE_SINGLE;
      start_step_q <= '0;
      stop_step_q  <= '0;
      delta_q      <= '0;
      dwell_m1_q   <= '0;
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      step_q       <= '0;
      step_load_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      start_step_q <= start_step_d;
      stop_step_q  <= stop_step_d;
      delta_q      <= delta_d;
      dwell_m1_q   <= dwell_m1_d;
      cnt_q        <= cnt_d;
      dir_down_q   <= dir_down_d;
      step_q       <= step_d;
      step_load_q  <= step_load_d;
      done_q       <= done_d;
    end
  end

  assign step_out  = step_q;
  assign step_load = step_load_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);

endmodule
